// File: rtl/stepper_move_ctrl_pkg.sv
// Shared state encoding and default timing constants for the stepper move controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stepper_move_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEL  = 3'd1,
        ST_CRUISE = 3'd2,
        ST_DECEL  = 3'd3,
        ST_FIN    = 3'd4
    } state_t;

    localparam int DEF_CNT_W      = 16;
    localparam int DEF_DIV_W      = 16;
    localparam int DEF_DIV_START  = 1000;
    localparam int DEF_DIV_MIN    = 100;
    localparam int DEF_DIV_STEP   = 50;

endpackage

// File: rtl/stepper_move_ctrl_step_timer.sv
// Loadable down-counter that paces step pulses; tick marks the last cycle of an interval.
// Latency: tick asserts value-1 cycles after the loading edge; the caller reloads on that edge.
// Backpressure: none; a load always wins over counting.
module stepper_move_ctrl_step_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] value,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // Count down to zero and park there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == DIV_W'(1));

endmodule

// File: rtl/stepper_move_ctrl.sv
// Relative-move step sequencer: emits STEP_EN pulses with a trapezoidal accel/cruise/decel profile.
// Latency: BUSY one cycle after START; first STEP_EN DIV_START cycles after the START edge; DONE one cycle after the last step.
// Backpressure: none; START is only honoured in IDLE and ignored while a move is running.
module stepper_move_ctrl
    import stepper_move_ctrl_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int DIV_W     = DEF_DIV_W,
    parameter int DIV_START = DEF_DIV_START,
    parameter int DIV_MIN   = DEF_DIV_MIN,
    parameter int DIV_STEP  = DEF_DIV_STEP
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [CNT_W-1:0] STEPS,
    input  logic             DIR,
    input  logic             MODE,
    input  logic             STOP,
    output logic             STEP_EN,
    output logic             UP_DOWN,
    output logic             HALF_FULL,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] POS
);

    // Interval arithmetic runs one bit wider so overflow/underflow is visible before clamping.
    localparam logic [DIV_W:0] START_W = (DIV_W+1)'(DIV_START);
    localparam logic [DIV_W:0] MIN_W   = (DIV_W+1)'(DIV_MIN);
    localparam logic [DIV_W:0] STEP_W  = (DIV_W+1)'(DIV_STEP);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] rem, rem_nxt, rem_eff, rem_dec;
    logic [CNT_W-1:0] ac, ac_nxt, ac_inc, ac_dec;
    logic [CNT_W-1:0] pos_nxt;
    logic [DIV_W-1:0] div, div_nxt, div_inc, div_dec;
    logic [DIV_W:0]   div_up, div_dn;
    logic             step_en_nxt, up_down_nxt, half_full_nxt, busy_nxt, done_nxt;
    logic             tmr_load, tick, speeding;

    stepper_move_ctrl_step_timer #(
        .DIV_W (DIV_W)
    ) u_step_timer (
        .clk   (CLK),
        .rst   (RESET),
        .load  (tmr_load),
        .value (div_nxt),
        .tick  (tick)
    );

    // Saturating interval and counter helpers used by the step evaluation.
    always_comb begin
        div_up  = {1'b0, div} + STEP_W;
        div_dn  = {1'b0, div} - STEP_W;
        div_inc = (div_up > START_W) ? START_W[DIV_W-1:0] : div_up[DIV_W-1:0];
        div_dec = (div_dn[DIV_W] || (div_dn < MIN_W)) ? MIN_W[DIV_W-1:0] : div_dn[DIV_W-1:0];
        ac_inc  = ac + CNT_W'(1);
        ac_dec  = (ac == '0) ? '0 : ac - CNT_W'(1);
        // A stop request shrinks the remaining distance to exactly what a mirrored decel needs.
        speeding = (state == ST_ACCEL) || (state == ST_CRUISE);
        rem_eff  = (speeding && STOP && (rem > ac_inc)) ? ac_inc : rem;
        rem_dec  = (rem_eff == '0) ? '0 : rem_eff - CNT_W'(1);
    end

    // Next-state and next-register decode; step bookkeeping happens on the timer tick edge.
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem;
        ac_nxt        = ac;
        div_nxt       = div;
        pos_nxt       = POS;
        step_en_nxt   = 1'b0;
        done_nxt      = 1'b0;
        busy_nxt      = BUSY;
        up_down_nxt   = UP_DOWN;
        half_full_nxt = HALF_FULL;
        tmr_load      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    if (STEPS != '0) begin
                        rem_nxt       = STEPS;
                        up_down_nxt   = DIR;
                        half_full_nxt = MODE;
                        busy_nxt      = 1'b1;
                        ac_nxt        = '0;
                        div_nxt       = START_W[DIV_W-1:0];
                        tmr_load      = 1'b1;
                        state_nxt     = ST_ACCEL;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                rem_nxt = rem_eff;
                if (tick) begin
                    step_en_nxt = 1'b1;
                    rem_nxt     = rem_dec;
                    pos_nxt     = UP_DOWN ? (POS + CNT_W'(1)) : (POS - CNT_W'(1));
                    if (rem_dec == '0) begin
                        state_nxt = ST_FIN;
                    end else begin
                        tmr_load = 1'b1;
                        if ((state != ST_DECEL) && (rem_dec <= ac)) begin
                            state_nxt = ST_DECEL;
                            div_nxt   = div_inc;
                            ac_nxt    = ac_dec;
                        end else if (state == ST_ACCEL) begin
                            div_nxt = div_dec;
                            ac_nxt  = ac_inc;
                            if (div_dec == MIN_W[DIV_W-1:0]) begin
                                state_nxt = ST_CRUISE;
                            end
                        end else if (state == ST_DECEL) begin
                            div_nxt = div_inc;
                            ac_nxt  = ac_dec;
                        end
                    end
                end
            end

            ST_FIN: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Move registers and registered outputs.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rem       <= '0;
            ac        <= '0;
            div       <= '0;
            POS       <= '0;
            STEP_EN   <= 1'b0;
            UP_DOWN   <= 1'b0;
            HALF_FULL <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            rem       <= rem_nxt;
            ac        <= ac_nxt;
            div       <= div_nxt;
            POS       <= pos_nxt;
            STEP_EN   <= step_en_nxt;
            UP_DOWN   <= up_down_nxt;
            HALF_FULL <= half_full_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
        end
    end

endmodule
